// File: rtl/whack_display_seq_if.sv
// whack_display_seq_if: game-state inputs and per-digit symbol codes of the display sequencer.
interface whack_display_seq_if #(
   parameter int SCORE_W = 10,
   parameter int TIME_W = 7
);
   logic tick, start, game_over;
   logic [SCORE_W-1:0] score;
   logic [TIME_W-1:0] time_left;
   logic [8:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic [1:0] mode;
   modport master (
      output tick, start, game_over, score, time_left,
      input hex0, hex1, hex2, hex3, hex4, hex5, mode
   );
   modport slave (
      input tick, start, game_over, score, time_left,
      output hex0, hex1, hex2, hex3, hex4, hex5, mode
   );
endinterface

// File: rtl/whack_display_seq.sv
// whack_display_seq: game-display FSM, banner scroll and shared serial binary-to-BCD feeding six HEX symbol codes.
module whack_display_seq #(
   parameter int SCORE_W = 10,
   parameter int SCORE_MAX = 999,
   parameter int TIME_W = 7,
   parameter int TIME_MAX = 99
) (
   input logic clk,
   input logic reset,
   whack_display_seq_if.slave bus
);
   localparam int BW = SCORE_W > TIME_W ? SCORE_W : TIME_W;
   localparam int CW = $clog2(BW + 1);
   localparam logic [8:0] BLANK = 9'd20;
   localparam logic [8:0] DASH = 9'd30;
   localparam logic [5:0] MSG [16] = '{6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd21, 6'd22,
                                      6'd23, 6'd24, 6'd25, 6'd20, 6'd33, 6'd34, 6'd35, 6'd36};
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_e;
   typedef enum logic [1:0] {LOAD, SHIFT, WRITE} phase_e;
   state_e state_q, state_d;
   phase_e phase_q, phase_d;
   logic [3:0] ptr_q, ptr_d;
   logic blink_q, blink_d;
   logic src_q, src_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bin_q, bin_d;
   logic [11:0] acc_q, acc_d, acc_sh;
   logic [11:0] sbcd_q, sbcd_d;
   logic [7:0] tbcd_q, tbcd_d;
   logic [5:0][8:0] hex_q, hex_d, idle_hex;
   logic [1:0] mode_q;
   logic [SCORE_W-1:0] score_c;
   logic [TIME_W-1:0] time_c;
   logic [8:0] s_h, s_t, s_o, t_t, t_o;
   always_ff @(posedge clk)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q == PLAY ? (bus.game_over ? DONE : PLAY)
              : (state_q == IDLE || state_q == DONE) ? (bus.start ? PLAY : state_q)
              : IDLE;
      ptr_d = state_d != state_q ? 4'd0 : ptr_q + 4'(state_q == IDLE && bus.tick);
      blink_d = state_d == state_q && (blink_q ^ (state_q == DONE && bus.tick));
   end
   assign score_c = bus.score > SCORE_W'(SCORE_MAX) ? SCORE_W'(SCORE_MAX) : bus.score;
   assign time_c = bus.time_left > TIME_W'(TIME_MAX) ? TIME_W'(TIME_MAX) : bus.time_left;
   // Sources are left-aligned so every shift takes the converter's MSB regardless of width.
   always_comb begin
      acc_sh = acc_q;
      for (int i = 0; i < 3; i++)
         if (acc_q[4*i +: 4] >= 4'd5) acc_sh[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      phase_d = phase_q == LOAD ? SHIFT : phase_q == SHIFT ? (cnt_q == '0 ? WRITE : SHIFT) : LOAD;
      cnt_d = phase_q == LOAD ? (src_q ? CW'(TIME_W - 1) : CW'(SCORE_W - 1)) : cnt_q - CW'(phase_q == SHIFT);
      bin_d = phase_q == LOAD ? (src_q ? BW'(time_c) << (BW - TIME_W) : BW'(score_c) << (BW - SCORE_W))
            : phase_q == SHIFT ? bin_q << 1 : bin_q;
      acc_d = phase_q == LOAD ? 12'd0 : phase_q == SHIFT ? 12'({acc_sh, bin_q[BW-1]}) : acc_q;
      src_d = phase_q == WRITE ? !src_q : src_q;
      sbcd_d = phase_q == WRITE && !src_q ? acc_q : sbcd_q;
      tbcd_d = phase_q == WRITE && src_q ? acc_q[7:0] : tbcd_q;
   end
   always_comb begin
      s_h = sbcd_q[11:8] == 4'd0 ? BLANK : {5'd0, sbcd_q[11:8]};
      s_t = sbcd_q[11:4] == 8'd0 ? BLANK : {5'd0, sbcd_q[7:4]};
      s_o = {5'd0, sbcd_q[3:0]};
      t_t = {5'd0, tbcd_q[7:4]};
      t_o = {5'd0, tbcd_q[3:0]};
      for (int i = 0; i < 6; i++) idle_hex[i] = {3'd0, MSG[ptr_q + 4'(5 - i)]};
      hex_d = state_q == PLAY ? {s_h, s_t, s_o, DASH, t_t, t_o}
            : state_q == DONE ? (blink_q ? {BLANK, BLANK, BLANK, s_h, s_t, s_o}
                                         : {9'd26, 9'd27, 9'd28, 9'd29, BLANK, BLANK})
            : idle_hex;
   end
   always_ff @(posedge clk)
      if (reset) begin
         phase_q <= LOAD;
         ptr_q <= '0;
         blink_q <= 1'b0;
         src_q <= 1'b0;
         cnt_q <= '0;
         bin_q <= '0;
         acc_q <= '0;
         sbcd_q <= '0;
         tbcd_q <= '0;
         hex_q <= {6{BLANK}};
         mode_q <= 2'd0;
      end else begin
         phase_q <= phase_d;
         ptr_q <= ptr_d;
         blink_q <= blink_d;
         src_q <= src_d;
         cnt_q <= cnt_d;
         bin_q <= bin_d;
         acc_q <= acc_d;
         sbcd_q <= sbcd_d;
         tbcd_q <= tbcd_d;
         hex_q <= hex_d;
         mode_q <= state_q;
      end
   assign bus.hex0 = hex_q[0];
   assign bus.hex1 = hex_q[1];
   assign bus.hex2 = hex_q[2];
   assign bus.hex3 = hex_q[3];
   assign bus.hex4 = hex_q[4];
   assign bus.hex5 = hex_q[5];
   assign bus.mode = mode_q;
endmodule

// File: doc/whack_display_seq.md
Name: whack_display_seq

Overview:
Upstream stage of the per-digit seven-segment decoders in the Whack-a-Mole game. It produces one 9-bit symbol code per HEX digit (six digits) from game state:
- a scrolling "START MOLE" banner when idle;
- live score and time remaining during play;
- an alternating "DONE"/final-score display at game end.

It contains the game-display FSM, a scroll pointer and a shared serial binary-to-BCD (double-dabble) converter. Each code output feeds one decoder instance.

Parameters:
SCORE_W, 10, width of score input
SCORE_MAX, 999, score clamp value before BCD conversion
TIME_W, 7, width of time_left input
TIME_MAX, 99, time clamp value before BCD conversion

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle pulse; advances scroll/blink (about 2-4 Hz)
start  input  1  one-cycle pulse; begin a game
game_over  input  1  one-cycle pulse; game has ended
score  input  SCORE_W  binary score
time_left  input  TIME_W  binary seconds remaining
hex0..hex5  output  9 each  symbol codes; hex5 is leftmost, hex0 is rightmost
mode  output  2  current state: 0 = IDLE, 1 = PLAY, 2 = DONE

Behaviour:
Symbol codes:
- 0-9: digits
- 20: blank
- 21-25: S, T, A, R, T
- 26-29: D, O, N, E
- 30: dash
- 33-36: M, O, L, E

Reset (synchronous):
- Outputs: all hexN = 20, mode = 0.
- Internal state: scroll ptr = 0, blink = 0, BCD registers = 0, converter idle, next conversion source = score.

FSM transitions:
- IDLE, start -> PLAY.
- PLAY, game_over -> DONE.
- DONE, start -> PLAY.
- game_over in IDLE or DONE is ignored; start in PLAY is ignored.
- start and game_over in the same cycle while in PLAY: game_over wins and the next state is DONE.
- Entering any state clears ptr and blink.

Scroll and blink:
- The message ROM has 16 entries: 20,20,20,20,20,20,21,22,23,24,25,20,33,34,35,36.
- In IDLE, hex5..hex0 = msg[ptr], msg[ptr+1], ..., msg[ptr+5]. Indices wrap modulo 16.
- Each tick in IDLE increments ptr; ptr wraps 15 -> 0.
- In DONE, each tick toggles blink.
- tick in PLAY has no effect.

BCD converter (shared, round-robin, runs continuously after reset):
- Cycle 1 (LOAD): sample the source, clamped to SCORE_MAX or TIME_MAX.
- Then W SHIFT cycles (W = SCORE_W for score, TIME_W for time): add-3 on any BCD nibble >= 5, then shift.
- Final cycle (WRITE): update that source's BCD register. Sources then alternate.
- A conversion is never aborted. Input changes mid-conversion are picked up at the next LOAD.

Display mapping:
- PLAY: hex5..hex3 = score hundreds, tens, ones; hex2 = 30 (dash); hex1..hex0 = time tens, ones.
  - Score leading zeros are blanked: hundreds = 20 if it is 0; tens = 20 if hundreds and tens are both 0.
  - Score ones and both time digits are never blanked.
- DONE, blink = 0: 26, 27, 28, 29, 20, 20.
- DONE, blink = 1: 20, 20, 20, then score BCD digits with the same blanking rule as PLAY.

Timing:
- hexN and mode are registered: one cycle after any state, ptr, blink or BCD change.
- Latency from a score or time_left change to the hex outputs is at most 34 cycles with default parameters.

Reset mid-conversion or mid-game: returns to the reset state on the next clock, with no residual digits.

Test Plan:
- Reset asserted for 2 cycles, then released with no tick -> all hexN = 20, mode = 0.
- IDLE, 6 ticks -> hex5..hex0 = 21, 22, 23, 24, 25, 20; after 16 total ticks, ptr has wrapped and the outputs are all 20 again.
- start; score = 7, time_left = 45; wait 40 cycles -> hex = 20, 20, 7, 30, 4, 5, mode = 1.
- PLAY, score = 1023 (above clamp), time_left = 120 (above clamp) -> within 34 cycles hex = 9, 9, 9, 30, 9, 9.
- PLAY, score = 105; start and game_over in the same cycle -> mode = 2 and hex = 26, 27, 28, 29, 20, 20; after one tick hex = 20, 20, 20, 1, 0, 5.
- Reset pulsed mid-conversion during PLAY -> next cycle mode = 0 and all hexN = 20; after 6 ticks IDLE scroll matches the second scenario.
